// File: rtl/ysyx_22040125_lsu_master_if.sv
// rtl/ysyx_22040125_lsu_master_if.sv - MEM-stage request/response and RAM data-port bundle for the LSU master
interface ysyx_22040125_lsu_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_ren;
    logic [3:0]  mem_rid;
    logic [31:0] mem_r_addr;
    logic [2:0]  mem_arsize;
    logic        mem_wen;
    logic [31:0] mem_w_addr;
    logic [2:0]  mem_awsize;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    modport master (
        input  req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_ren, mem_rid, mem_r_addr, mem_arsize,
        output mem_wen, mem_w_addr, mem_awsize, mem_wdata
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_ren, mem_rid, mem_r_addr, mem_arsize,
        input  mem_wen, mem_w_addr, mem_awsize, mem_wdata
    );
endinterface

// File: rtl/ysyx_22040125_lsu_master.sv
// rtl/ysyx_22040125_lsu_master.sv - single-outstanding load/store initiator to the unified RAM model
// LSU_MISALIGN_TRAP_EN: misaligned requests return resp_err instead of being force-aligned.
module ysyx_22040125_lsu_master #(
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter int          RD_LAT    = 1
) (
    input logic clk,
    input logic rst,
    ysyx_22040125_lsu_master_if.master bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        req_ready;
    logic        resp_valid;
    logic        mem_ren;
    logic        mem_wen;
    logic        accept;
    logic        err_req;
    logic [31:0] addr_eff;
    logic [2:0]  size_oh;
    logic [63:0] rd_ext;

    logic [31:0] off_q;
    logic [2:0]  oh_q;
    logic        uns_q;
    logic [63:0] wdata_q;
    logic [3:0]  cnt_q;
    logic [63:0] rdata_q;
    logic        err_q;

    logic        unused;
    assign unused = ^bus.req_addr[63:32];

    assign accept = bus.req_valid && req_ready;

    always_comb begin
        size_oh = 3'b000;
        case (bus.req_size)
            2'd0:    size_oh = 3'b100;
            2'd1:    size_oh = 3'b010;
            2'd2:    size_oh = 3'b001;
            default: size_oh = 3'b000;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            2'd1:    misaligned = bus.req_addr[0];
            2'd2:    misaligned = |bus.req_addr[1:0];
            2'd3:    misaligned = |bus.req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end
    assign err_req  = misaligned;
    assign addr_eff = bus.req_addr[31:0];
`else
    // Without the trap, silently round the address down to natural alignment.
    always_comb begin
        addr_eff = bus.req_addr[31:0];
        case (bus.req_size)
            2'd1:    addr_eff = {bus.req_addr[31:1], 1'b0};
            2'd2:    addr_eff = {bus.req_addr[31:2], 2'b00};
            2'd3:    addr_eff = {bus.req_addr[31:3], 3'b000};
            default: addr_eff = bus.req_addr[31:0];
        endcase
    end
    assign err_req = 1'b0;
`endif

    // The RAM always sign-extends, so unsigned loads mask the upper bits here.
    always_comb begin
        rd_ext = bus.mem_rdata;
        if (uns_q) begin
            case (oh_q)
                3'b100:  rd_ext = {56'd0, bus.mem_rdata[7:0]};
                3'b010:  rd_ext = {48'd0, bus.mem_rdata[15:0]};
                3'b001:  rd_ext = {32'd0, bus.mem_rdata[31:0]};
                default: rd_ext = bus.mem_rdata;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (err_req) begin
                        state_nxt = RESP;
                    end else if (bus.req_wen) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD: begin
                mem_ren = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            WR: begin
                mem_wen   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            off_q   <= 32'd0;
            oh_q    <= 3'b000;
            uns_q   <= 1'b0;
            wdata_q <= 64'd0;
            cnt_q   <= 4'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            off_q   <= addr_eff - ADDR_BASE;
            oh_q    <= size_oh;
            uns_q   <= bus.req_unsigned;
            wdata_q <= bus.req_wdata;
            cnt_q   <= 4'(RD_LAT - 1);
            rdata_q <= 64'd0;
            err_q   <= err_req;
        end else if (state == RD) begin
            if (cnt_q == 4'd0) begin
                rdata_q <= rd_ext;
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_ren    = mem_ren;
    assign bus.mem_rid    = 4'd1;
    assign bus.mem_r_addr = off_q;
    assign bus.mem_arsize = oh_q;
    assign bus.mem_wen    = mem_wen;
    assign bus.mem_w_addr = off_q;
    assign bus.mem_awsize = oh_q;
    assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_ysyx_22040125_lsu_master.sv
// tb/tb_ysyx_22040125_lsu_master.sv - vector, random and corner-sequence bench for the LSU master
module tb_ysyx_22040125_lsu_master;

    localparam int          RD_LAT = 1;
    localparam logic [31:0] BASE   = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] ram_word = 64'd0;
    int          checks = 0;
    int          errors = 0;

    ysyx_22040125_lsu_master_if bus();

    ysyx_22040125_lsu_master #(.ADDR_BASE(BASE), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // RAM model: sign-extends the stored word according to the requested size.
    always_comb begin
        bus.mem_rdata = ram_word;
        case (bus.mem_arsize)
            3'b100:  bus.mem_rdata = {{56{ram_word[7]}},  ram_word[7:0]};
            3'b010:  bus.mem_rdata = {{48{ram_word[15]}}, ram_word[15:0]};
            3'b001:  bus.mem_rdata = {{32{ram_word[31]}}, ram_word[31:0]};
            default: bus.mem_rdata = ram_word;
        endcase
    end

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] wdata;
        logic [63:0] ram;
        logic [63:0] e_rdata;
        logic [31:0] e_off;
        logic [2:0]  e_sz;
        logic        e_err;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] ram, output vec_t v);
        longint unsigned align;
        logic            mis;
        int              bits;
        logic signed [63:0] sx;
        align = 64'd1 << size;
        mis   = (addr % align) != 0;
        v.wen = wen; v.addr = addr; v.size = size; v.uns = uns; v.ram = ram;
`ifdef LSU_MISALIGN_TRAP_EN
        v.e_err = mis;
        v.e_off = addr[31:0] - BASE;
`else
        v.e_err = 1'b0;
        v.e_off = 32'(addr - (addr % align)) - BASE;
`endif
        v.e_sz = (size == 2'd3) ? 3'b000 : (3'b100 >> size);
        bits = 8 << size;
        if (wen || v.e_err) begin
            v.e_rdata = 64'd0;
        end else if (size == 2'd3) begin
            v.e_rdata = ram;
        end else if (uns) begin
            v.e_rdata = ram & ((64'd1 << bits) - 64'd1);
        end else begin
            sx = $signed(ram << (64 - bits));
            v.e_rdata = 64'(sx >>> (64 - bits));
        end
    endtask

    task automatic txn(input string nm, input vec_t v);
        int          lat = 0;
        int          rens = 0;
        int          wens = 0;
        int          both = 0;
        int          e_lat;
        logic [31:0] got_off = 32'd0;
        logic [2:0]  got_sz = 3'd7;
        logic [63:0] got_wd = 64'd0;
        ram_word = v.ram;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_wen      = v.wen;
        bus.req_addr     = v.addr;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_wdata    = v.wdata;
        chk({nm, " req_ready"}, 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.mem_ren) begin
                rens++; got_off = bus.mem_r_addr; got_sz = bus.mem_arsize;
            end
            if (bus.mem_wen) begin
                wens++; got_off = bus.mem_w_addr; got_sz = bus.mem_awsize; got_wd = bus.mem_wdata;
            end
            if (bus.mem_ren && bus.mem_wen) both++;
            if (bus.resp_valid) break;
        end
        e_lat = v.e_err ? 1 : (v.wen ? 2 : RD_LAT + 1);
        chk({nm, " latency"}, 64'(lat), 64'(e_lat));
        chk({nm, " resp_valid"}, 64'(bus.resp_valid), 64'd1);
        chk({nm, " resp_err"}, 64'(bus.resp_err), 64'(v.e_err));
        chk({nm, " resp_rdata"}, bus.resp_rdata, v.e_rdata);
        chk({nm, " ren_cycles"}, 64'(rens), (v.e_err || v.wen) ? 64'd0 : 64'(RD_LAT));
        chk({nm, " wen_cycles"}, 64'(wens), (v.wen && !v.e_err) ? 64'd1 : 64'd0);
        chk({nm, " ren_wen_overlap"}, 64'(both), 64'd0);
        if (!v.e_err) begin
            chk({nm, " offset"}, 64'(got_off), 64'(v.e_off));
            chk({nm, " size_oh"}, 64'(got_sz), 64'(v.e_sz));
        end
        if (v.wen && !v.e_err) chk({nm, " wdata"}, got_wd, v.wdata);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        chk({nm, " resp_drop"}, 64'(bus.resp_valid), 64'd0);
    endtask

    vec_t vecs[9];
    vec_t rv;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = 64'd0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_wdata = 64'd0; bus.resp_ready = 1'b0;

        #1;
        chk("rst req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst resp_err", 64'(bus.resp_err), 64'd0);
        chk("rst resp_rdata", bus.resp_rdata, 64'd0);
        chk("rst mem_ren", 64'(bus.mem_ren), 64'd0);
        chk("rst mem_wen", 64'(bus.mem_wen), 64'd0);
        chk("rst addrs", {bus.mem_r_addr, bus.mem_w_addr}, 64'd0);
        chk("rst sizes", 64'({bus.mem_arsize, bus.mem_awsize}), 64'd0);
        chk("rst wdata", bus.mem_wdata, 64'd0);
        chk("rst rid", 64'(bus.mem_rid), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        //            wen   addr                    sz    uns   wdata                   ram                     e_rdata                 e_off         e_sz    e_err
        vecs[0] = '{1'b0, 64'h0000_0000_8000_0003, 2'd0, 1'b1, 64'd0,                  64'hFFFF_FFFF_FFFF_FF9A, 64'h0000_0000_0000_009A, 32'h3,   3'b100, 1'b0};
        vecs[1] = '{1'b0, 64'h0000_0000_8000_0010, 2'd2, 1'b0, 64'd0,                  64'hFFFF_FFFF_8000_0001, 64'hFFFF_FFFF_8000_0001, 32'h10,  3'b001, 1'b0};
        vecs[2] = '{1'b1, 64'h0000_0000_8000_0100, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 64'd0,                  64'd0,                   32'h100, 3'b000, 1'b0};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[3] = '{1'b1, 64'h0000_0000_8000_0002, 2'd2, 1'b0, 64'hDEAD_BEEF,           64'd0,                  64'd0,                   32'h0,   3'b001, 1'b1};
`else
        vecs[3] = '{1'b1, 64'h0000_0000_8000_0002, 2'd2, 1'b0, 64'hDEAD_BEEF,           64'd0,                  64'd0,                   32'h0,   3'b001, 1'b0};
`endif
        vecs[4] = '{1'b0, 64'h0000_0000_8000_0006, 2'd1, 1'b1, 64'd0,                  64'h0000_0000_0000_8001, 64'h0000_0000_0000_8001, 32'h6,   3'b010, 1'b0};
        vecs[5] = '{1'b0, 64'h0000_0000_8000_0008, 2'd3, 1'b0, 64'd0,                  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 32'h8,   3'b000, 1'b0};
        vecs[6] = '{1'b0, 64'h0000_0000_8000_0020, 2'd1, 1'b0, 64'd0,                  64'h0000_0000_0000_F00D, 64'hFFFF_FFFF_FFFF_F00D, 32'h20,  3'b010, 1'b0};
        vecs[7] = '{1'b1, 64'h0000_0000_8000_0007, 2'd0, 1'b0, 64'h0000_0000_0000_00AB, 64'd0,                  64'd0,                   32'h7,   3'b100, 1'b0};
        vecs[8] = '{1'b0, 64'h0000_0000_8000_0004, 2'd2, 1'b1, 64'd0,                  64'hFFFF_FFFF_DEAD_BEEF, 64'h0000_0000_DEAD_BEEF, 32'h4,   3'b001, 1'b0};
        for (int i = 0; i < 9; i++) txn($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 40; i++) begin
            logic [63:0] a;
            a = {$urandom, BASE + 32'($urandom_range(0, 4095))};
            model(1'($urandom), a, 2'($urandom), 1'($urandom), {$urandom, $urandom}, rv);
            rv.wdata = {$urandom, $urandom};
            txn($sformatf("rnd%0d", i), rv);
        end

        // Asynchronous reset in the middle of a load.
        ram_word = 64'h55;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_addr = 64'h8000_0040; bus.req_size = 2'd3;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("mid ren_before_rst", 64'(bus.mem_ren), 64'd1);
        rst = 1'b0;
        #1;
        chk("async mem_ren", 64'(bus.mem_ren), 64'd0);
        chk("async mem_wen", 64'(bus.mem_wen), 64'd0);
        chk("async req_ready", 64'(bus.req_ready), 64'd1);
        chk("async resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("async resp_rdata", bus.resp_rdata, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Backpressure, then a waiting request is taken on the following IDLE cycle.
        ram_word = 64'h1234_F00D;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_addr = 64'h8000_0002;
        bus.req_size = 2'd1; bus.req_unsigned = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 0; k < 40 && !bus.resp_valid; k++) @(negedge clk);
        bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_addr = 64'h8000_0005;
        bus.req_size = 2'd0; bus.req_wdata = 64'hAB;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp resp_valid", 64'(bus.resp_valid), 64'd1);
            chk("bp resp_rdata", bus.resp_rdata, 64'h0000_0000_0000_F00D);
            chk("bp req_ready", 64'(bus.req_ready), 64'd0);
            chk("bp mem_wen", 64'(bus.mem_wen), 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        chk("bp idle req_ready", 64'(bus.req_ready), 64'd1);
        chk("bp idle resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("bp idle mem_wen", 64'(bus.mem_wen), 64'd0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("bp2 mem_wen", 64'(bus.mem_wen), 64'd1);
        chk("bp2 w_addr", 64'(bus.mem_w_addr), 64'h5);
        chk("bp2 awsize", 64'(bus.mem_awsize), 64'b100);
        chk("bp2 wdata", bus.mem_wdata, 64'hAB);
        @(negedge clk);
        chk("bp2 resp_valid", 64'(bus.resp_valid), 64'd1);
        chk("bp2 resp_rdata", bus.resp_rdata, 64'd0);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
